// File: rtl/sqrt_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sqrt_arb_pkg
// Description : Shared types and constants for the square-root arbiter.
//               Holds the FSM state encoding, the datapath width and the
//               requester-index width helper.
// Ports       : none (package)
// Config      : none
// Revision    : 1.0 - initial release
// ============================================================================
package sqrt_arb_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_t;

  // Width of a requester index; never below one bit.
  function automatic int ID_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sqrt.sv
`default_nettype none
// ============================================================================
// Module      : sqrt
// Description : Iterative integer square-root core, one result bit per cycle
//               (restoring digit-by-digit method). result_o = floor(sqrt(a_i)).
//               valid_o rises when a result is ready, stays high until the
//               next accepted start_i, and is cleared on that accept.
// Ports       : clk_i    - clock
//               rst_i    - synchronous active-high reset
//               start_i  - accept a_i and begin a computation
//               a_i      - operand
//               valid_o  - result ready (level)
//               result_o - root, zero-extended to DATA_W
// Config      : none
// Revision    : 1.0 - initial release
// ============================================================================
module sqrt #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] result_o
);

  localparam int ROOT_W = DATA_W / 2;
  // Partial remainder never exceeds 2*root+1 before the shift, so two spare
  // bits above the 2-bit digit shift are enough.
  localparam int REM_W  = ROOT_W + 4;
  localparam int CNT_W  = $clog2(ROOT_W) + 1;

  logic [DATA_W-1:0] x;
  logic [REM_W-1:0]  rem;
  logic [ROOT_W-1:0] root;
  logic [CNT_W-1:0]  cnt;
  logic              running;

  logic [REM_W-1:0]  rem_sh;
  logic [REM_W-1:0]  trial;
  logic              ge;

  always_comb begin
    rem_sh = {rem[REM_W-3:0], x[DATA_W-1 -: 2]};
    trial  = REM_W'({root, 2'b01});
    ge     = (rem_sh >= trial);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x       <= '0;
      rem     <= '0;
      root    <= '0;
      cnt     <= '0;
      running <= 1'b0;
      valid_o <= 1'b0;
    end else if (start_i) begin
      x       <= a_i;
      rem     <= '0;
      root    <= '0;
      cnt     <= CNT_W'(ROOT_W);
      running <= 1'b1;
      valid_o <= 1'b0;
    end else if (running) begin
      x    <= x << 2;
      rem  <= ge ? (rem_sh - trial) : rem_sh;
      root <= {root[ROOT_W-2:0], ge};
      cnt  <= cnt - 1'b1;
      if (cnt == CNT_W'(1)) begin
        running <= 1'b0;
        valid_o <= 1'b1;
      end
    end
  end

  assign result_o = {{(DATA_W-ROOT_W){1'b0}}, root};

endmodule
`default_nettype wire

// File: rtl/sqrt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sqrt_arbiter
// Description : Round-robin arbiter sharing one iterative square-root core
//               among NUM_REQ requesters. One operation is in flight at a
//               time; the winner is chosen in IDLE and pulsed on gnt_o in
//               GRANT, the core is started in START, and the result is
//               returned with its requester index in RESP.
// Ports       : clk_i       - clock
//               rst_i       - synchronous active-high reset
//               req_i       - per-requester request
//               a_i         - per-requester operands, slice k = [k*32 +: 32]
//               gnt_o       - one-hot grant pulse
//               rsp_valid_o - result pulse
//               rsp_id_o    - owner of the result
//               rsp_data_o  - floor(sqrt(operand)), held until next result
//               busy_o      - operation in flight
//               perf_cnt_o  - result counter (only with SQRT_ARB_PERF_EN)
// Config      : SQRT_ARB_PERF_EN - adds perf_cnt_o counting rsp_valid_o
// Revision    : 1.0 - initial release
// ============================================================================
module sqrt_arbiter
  import sqrt_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = sqrt_arb_pkg::DATA_W
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [NUM_REQ*DATA_W-1:0]       a_i,
  output logic [NUM_REQ-1:0]              gnt_o,
  output logic                            rsp_valid_o,
  output logic [ID_W(NUM_REQ)-1:0]        rsp_id_o,
  output logic [DATA_W-1:0]               rsp_data_o,
  output logic                            busy_o
`ifdef SQRT_ARB_PERF_EN
  ,
  output logic [31:0]                     perf_cnt_o
`endif
);

  localparam int IDW = ID_W(NUM_REQ);

  state_t            state;
  logic [IDW-1:0]    last_grant;
  logic [IDW-1:0]    id_q;
  logic [DATA_W-1:0] op_q;
  logic              core_start;
  logic              first_wait;
  logic              core_valid;
  logic [DATA_W-1:0] core_result;

  logic [DATA_W-1:0] ops [NUM_REQ];
  logic [IDW-1:0]    winner;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_ops
    assign ops[k] = a_i[k*DATA_W +: DATA_W];
  end

  // Round-robin pick starting at last_grant+1. Scanning from the far end
  // down lets the nearest requesting index overwrite any farther one.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = (int'(last_grant) + i) % NUM_REQ;
      if (req_i[IDW'(idx)]) begin
        winner = IDW'(idx);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      gnt_o       <= '0;
      rsp_valid_o <= 1'b0;
      rsp_id_o    <= '0;
      rsp_data_o  <= '0;
      busy_o      <= 1'b0;
      last_grant  <= IDW'(NUM_REQ - 1);
      id_q        <= '0;
      op_q        <= '0;
      core_start  <= 1'b0;
      first_wait  <= 1'b0;
    end else begin
      gnt_o       <= '0;
      rsp_valid_o <= 1'b0;
      core_start  <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_i) begin
            gnt_o      <= NUM_REQ'(1) << winner;
            op_q       <= ops[winner];
            id_q       <= winner;
            last_grant <= winner;
            busy_o     <= 1'b1;
            state      <= GRANT;
          end
        end
        GRANT: begin
          core_start <= 1'b1;
          state      <= START;
        end
        START: begin
          first_wait <= 1'b1;
          state      <= WAIT;
        end
        WAIT: begin
          first_wait <= 1'b0;
          // The core's valid only reflects the new operation after the
          // accept has taken effect, so the first WAIT cycle is skipped.
          if (!first_wait && core_valid) begin
            rsp_data_o  <= core_result;
            rsp_id_o    <= id_q;
            rsp_valid_o <= 1'b1;
            busy_o      <= 1'b0;
            state       <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  sqrt #(
    .DATA_W (DATA_W)
  ) u_sqrt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (core_start),
    .a_i      (op_q),
    .valid_o  (core_valid),
    .result_o (core_result)
  );

`ifdef SQRT_ARB_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_cnt_o <= '0;
    end else if (rsp_valid_o) begin
      perf_cnt_o <= perf_cnt_o + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sqrt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sqrt_arbiter
// Description : Self-checking bench for sqrt_arbiter. Stimulus pushes the
//               expected grants and responses into queues; a monitor pops
//               and compares whenever the DUT pulses gnt_o or rsp_valid_o.
// Config      : SQRT_ARB_PERF_EN - also checks perf_cnt_o
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sqrt_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;

  typedef struct {
    int          id;
    logic [31:0] data;
  } rsp_t;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] a;
  logic [NUM_REQ-1:0]        gnt;
  logic                      rsp_valid;
  logic [1:0]                rsp_id;
  logic [DATA_W-1:0]         rsp_data;
  logic                      busy;
`ifdef SQRT_ARB_PERF_EN
  logic [31:0]               perf_cnt;
`endif

  int   checks   = 0;
  int   failures = 0;
  int   grants_seen = 0;
  int   grants_expected = 0;
  logic prev_busy = 1'b0;

  int   gnt_q[$];
  rsp_t rsp_q[$];

  sqrt_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .a_i         (a),
    .gnt_o       (gnt),
    .rsp_valid_o (rsp_valid),
    .rsp_id_o    (rsp_id),
    .rsp_data_o  (rsp_data),
    .busy_o      (busy)
`ifdef SQRT_ARB_PERF_EN
    ,
    .perf_cnt_o  (perf_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every grant and response against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (gnt != '0) begin
        grants_seen++;
        check("gnt_onehot", 32'($onehot(gnt)), 32'd1);
        check("gnt_while_busy", 32'(prev_busy), 32'd0);
        if (gnt_q.size() == 0) begin
          check("gnt_unexpected", 32'(gnt), 32'd0);
        end else begin
          check("gnt_order", 32'(gnt), 32'(1) << gnt_q.pop_front());
        end
      end
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          rsp_t e;
          e = rsp_q.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(e.id));
          check("rsp_data", rsp_data, e.data);
        end
      end
    end
    prev_busy = busy;
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int k);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(posedge clk);
      #1;
      if (gnt[k]) got = 1'b1;
    end
    if (!got) check("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while (rsp_q.size() != 0 && c < 200) begin
      @(posedge clk);
      c++;
    end
    if (rsp_q.size() != 0) begin
      check("rsp_timeout", 32'(rsp_q.size()), 32'd0);
      rsp_q.delete();
    end
    cycles(3);
  endtask

  task automatic run_one(input int k, input logic [31:0] op, input logic [31:0] exp_root);
    rsp_t e;
    a[k*DATA_W +: DATA_W] = op;
    e.id = k;
    e.data = exp_root;
    gnt_q.push_back(k);
    grants_expected++;
    rsp_q.push_back(e);
    req[k] = 1'b1;
    wait_gnt(k);
    req[k] = 1'b0;
    wait_drain();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    req = '0;
    a   = '0;
    cycles(3);
    rst = 1'b0;

    check("reset_gnt", 32'(gnt), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    check("reset_rsp_data", rsp_data, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    // Single request, then boundaries on requester 2.
    run_one(0, 32'd16, 32'd4);
    run_one(2, 32'd0, 32'd0);
    run_one(2, 32'hFFFF_FFFF, 32'h0000_FFFF);
    run_one(2, 32'd15, 32'd3);
    run_one(3, 32'd1_000_000, 32'd1000);

    // Contention: all four held, a_k = k*k+1.
    pulse_reset();
    begin
      int n;
      rsp_t e;
      for (int k = 0; k < NUM_REQ; k++) a[k*DATA_W +: DATA_W] = 32'(k*k + 1);
      for (int k = 0; k < NUM_REQ; k++) gnt_q.push_back(k);
      gnt_q.push_back(0);
      grants_expected += 5;
      e.id = 0; e.data = 32'd1; rsp_q.push_back(e);
      e.id = 1; e.data = 32'd1; rsp_q.push_back(e);
      e.id = 2; e.data = 32'd2; rsp_q.push_back(e);
      e.id = 3; e.data = 32'd3; rsp_q.push_back(e);
      e.id = 0; e.data = 32'd1; rsp_q.push_back(e);
      req = '1;
      n = 0;
      for (int c = 0; c < 400 && n < 5; c++) begin
        @(posedge clk);
        #1;
        if (gnt != '0) n++;
      end
      req = '0;
      check("contention_grants", 32'(n), 32'd5);
      wait_drain();
    end
`ifdef SQRT_ARB_PERF_EN
    check("perf_after_5", perf_cnt, 32'd5);
`endif

    // Reset in WAIT: no response, all outputs cleared.
    a[2*DATA_W +: DATA_W] = 32'd100;
    gnt_q.push_back(2);
    grants_expected++;
    req[2] = 1'b1;
    wait_gnt(2);
    req[2] = 1'b0;
    cycles(4);
    pulse_reset();
    check("midrst_gnt", 32'(gnt), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_rsp_id", 32'(rsp_id), 32'd0);
    check("midrst_rsp_data", rsp_data, 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
`ifdef SQRT_ARB_PERF_EN
    check("perf_after_reset", perf_cnt, 32'd0);
`endif
    cycles(30);
    run_one(2, 32'd81, 32'd9);

    // Withdrawal: requester 1 pulses while requester 0 is served.
    begin
      rsp_t e;
      a[0 +: DATA_W] = 32'd49;
      a[DATA_W +: DATA_W] = 32'd64;
      gnt_q.push_back(0);
      grants_expected++;
      e.id = 0; e.data = 32'd7; rsp_q.push_back(e);
      req[0] = 1'b1;
      wait_gnt(0);
      req[0] = 1'b0;
      cycles(3);
      req[1] = 1'b1;
      cycles(2);
      req[1] = 1'b0;
      wait_drain();
      cycles(10);
    end

    check("grant_total", 32'(grants_seen), 32'(grants_expected));
    check("gnt_queue_empty", 32'(gnt_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sqrt_arbiter.md
SQRT_ARBITER -- requirements
Module: sqrt_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one square-root core; legal range 2..8.
REQ-002 Parameter DATA_W, default 32: operand and result width; fixed at 32, matching the core.
REQ-003 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  reset; synchronous and active-high.
REQ-005 req_i  input  NUM_REQ  per-requester request; held high until the matching gnt_o bit pulses.
REQ-006 a_i  input  NUM_REQ*DATA_W  per-requester operands; slice k is bits [k*32 +: 32], stable while req_i[k] is high.
REQ-007 gnt_o  output  NUM_REQ  one-hot, one-cycle pulse; the operand of the granted requester is captured in that cycle.
REQ-008 rsp_valid_o  output  1  one-cycle pulse; the result is available.
REQ-009 rsp_id_o  output  clog2(NUM_REQ)  index of the requester that owns the result; valid only with rsp_valid_o.
REQ-010 rsp_data_o  output  DATA_W  floor(sqrt(operand)); held until the next rsp_valid_o.
REQ-011 busy_o  output  1  high from the grant cycle until the cycle in which rsp_valid_o pulses.

Function
REQ-012 FSM states and transitions:
- IDLE: go to GRANT when any req_i bit is high.
- GRANT: go to START.
- START: go to WAIT.
- WAIT: go to RESP when the core's valid_o is high.
- RESP: go to IDLE.
REQ-013 Grant decision in IDLE (registered, one cycle):
- winner is the first requester with req_i set, scanning round-robin from (last_grant+1) mod NUM_REQ;
- in GRANT, gnt_o[winner] pulses, a_i[winner] is latched into op_q, and winner is latched into id_q and last_grant.
REQ-014 START drives the core's start_i high for exactly one cycle with op_q on the core's a_i; the core's start_i is low in every other state.
REQ-015 WAIT ignores the core's valid_o in the first WAIT cycle, because the core clears valid on accept.
- After that, core valid_o=1 latches the core's result_o into rsp_data_o and id_q into rsp_id_o.
- rsp_valid_o pulses in the RESP cycle.
REQ-016 Latency from grant to rsp_valid_o is 3 + the core's compute cycles; no new grant is issued before RESP completes.
REQ-017 gnt_o is zero outside GRANT and carries at most one set bit.
REQ-018 A requester may re-assert req_i in or after its own RESP cycle; it then competes under round-robin.
REQ-019 A req_i bit that drops before its grant is not granted; no operand is consumed for it.
REQ-020 Operand boundaries: a=0 returns 0; a=0xFFFFFFFF returns 0xFFFF; perfect squares return exact roots.

Reset
REQ-021 rst_i=1 at a clock edge forces:
- FSM to IDLE;
- gnt_o=0, rsp_valid_o=0, rsp_id_o=0, rsp_data_o=0, busy_o=0;
- last_grant=NUM_REQ-1, so requester 0 wins first.
REQ-022 The core's rst_i is driven by rst_i. A reset mid-operation abandons the operation without rsp_valid_o, and the first request after reset is granted normally.

Configuration
REQ-023 Macro SQRT_ARB_PERF_EN.
- Defined: adds output perf_cnt_o, 32 bits, which counts rsp_valid_o pulses, wraps at 2^32, and is cleared by reset.
- Undefined: the port and its counter are absent, with no other behavioural change.

Structure
REQ-024 Package sqrt_arb_pkg holds:
- the FSM state enum (IDLE, GRANT, START, WAIT, RESP);
- the DATA_W constant;
- an ID_W function (clog2 of the requester count).
REQ-025 Exactly one sub-module, the existing square-root core, named sqrt, instanced as u_sqrt; the round-robin picker is inline logic, not a module.

Verification
REQ-026 Single request, req_i=0001 with a_0=16: gnt_o=0001 once; then rsp_valid_o once with rsp_id_o=0, rsp_data_o=4.
REQ-027 Boundaries, one at a time on requester 2: a=0 -> 0; a=0xFFFFFFFF -> 0xFFFF; a=15 -> 3; rsp_id_o=2 each time.
REQ-028 Contention: req_i=1111 held continuously with a_k=k*k+1:
- grants occur in order 0,1,2,3,0;
- results are 1,1,2,3;
- no gnt_o pulse occurs while busy_o=1 outside GRANT.
REQ-029 Reset mid-operation: rst_i pulsed in WAIT -> all outputs 0 the next cycle, no rsp_valid_o; then req_i=0100, a_2=81 -> rsp_data_o=9, rsp_id_o=2.
REQ-030 Request withdrawal: req_i[1] rises and falls while requester 0 is being served -> requester 1 is never granted.
REQ-031 With SQRT_ARB_PERF_EN: after REQ-028's five results, perf_cnt_o=5; after reset, 0.
